// File: rtl/fetch_pkg.sv
// Shared definitions for the RV32 fetch stage and the opcode-driven controller.
//   - datapath widths and the default reset PC
//   - fetch FSM state encoding
//   - RV32I major opcode constants (instr[6:0])
package fetch_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned OPCODE_W    = 7;
  localparam int unsigned INSTR_BYTES = 4;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StDrain,
    StValid,
    StHalt
  } fetch_state_t;

  // RV32I major opcodes, decoded by the controller from opcode_o.
  localparam logic [OPCODE_W-1:0] OpLoad   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OpFence  = 7'b0001111;
  localparam logic [OPCODE_W-1:0] OpImm    = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OpAuipc  = 7'b0010111;
  localparam logic [OPCODE_W-1:0] OpStore  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OpReg    = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OpLui    = 7'b0110111;
  localparam logic [OPCODE_W-1:0] OpBranch = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OpJalr   = 7'b1100111;
  localparam logic [OPCODE_W-1:0] OpJal    = 7'b1101111;
  localparam logic [OPCODE_W-1:0] OpSystem = 7'b1110011;

  // Instruction addresses must be word aligned.
  function automatic logic is_aligned(logic [XLEN-1:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC selection for the fetch stage (purely combinational).
//   pc_i            current PC
//   flush_i         flush request (already qualified by the caller)
//   flush_pc_i      flush target
//   redirect_i      taken branch (already qualified by the consume handshake)
//   redirect_pc_i   branch target
//   next_pc_o       selected PC: flush > redirect > pc+4 (wraps modulo 2^32)
//   misaligned_o    selected PC is not word aligned
module fetch_next_pc
  import fetch_pkg::*;
(
  input  logic [XLEN-1:0] pc_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] flush_pc_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic [XLEN-1:0] next_pc_o,
  output logic            misaligned_o
);

  always_comb begin
    next_pc_o = pc_i + XLEN'(INSTR_BYTES);
    if (flush_i) begin
      next_pc_o = flush_pc_i;
    end else if (redirect_i) begin
      next_pc_o = redirect_pc_i;
    end
    misaligned_o = !is_aligned(next_pc_o);
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage of the RV32 single-cycle core.
// Holds the PC, keeps at most one instruction-memory request outstanding, and
// presents the returned word plus its opcode field downstream. Redirects are
// taken only at the consume handshake; flushes restart fetch and drain any
// in-flight response. A misaligned target parks the stage in HALT until reset.
//   clk_i, rst_i          clock, synchronous active-high reset
//   imem_req_o/addr_o     fetch request and byte address
//   imem_ready_i          memory accepts the request this cycle
//   imem_rvalid_i/rdata_i response word
//   instr_valid_o/instr_o/opcode_o/pc_o   instruction to controller/decode
//   instr_ready_i         downstream consumes the instruction
//   redirect_i/pc_i       taken branch for the consumed instruction
//   flush_i/flush_pc_i    discard current fetch, restart at flush_pc_i
//   misaligned_o          sticky misaligned-target error
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                clk_i,
  input  logic                rst_i,
  output logic                imem_req_o,
  output logic [XLEN-1:0]     imem_addr_o,
  input  logic                imem_ready_i,
  input  logic                imem_rvalid_i,
  input  logic [XLEN-1:0]     imem_rdata_i,
  output logic                instr_valid_o,
  output logic [XLEN-1:0]     instr_o,
  output logic [OPCODE_W-1:0] opcode_o,
  output logic [XLEN-1:0]     pc_o,
  input  logic                instr_ready_i,
  input  logic                redirect_i,
  input  logic [XLEN-1:0]     redirect_pc_i,
  input  logic                flush_i,
  input  logic [XLEN-1:0]     flush_pc_i,
  output logic                misaligned_o
);

  fetch_state_t    state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] instr_q;

  logic            flush_act;
  logic            consume;
  logic            take_new_pc;
  logic [XLEN-1:0] next_pc;
  logic            next_misaligned;

  assign flush_act   = flush_i && (state_q != StHalt);
  assign consume     = (state_q == StValid) && instr_ready_i;
  assign take_new_pc = flush_act || consume;

  fetch_next_pc u_next_pc (
    .pc_i          (pc_q),
    .flush_i       (flush_act),
    .flush_pc_i    (flush_pc_i),
    .redirect_i    (consume && redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .next_pc_o     (next_pc),
    .misaligned_o  (next_misaligned)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      instr_q <= '0;
    end else if (take_new_pc && next_misaligned) begin
      // Keep the offending target in pc_q so pc_o reports it while halted.
      state_q <= StHalt;
      pc_q    <= next_pc;
    end else begin
      if (take_new_pc) begin
        pc_q <= next_pc;
      end
      unique case (state_q)
        StIdle: state_q <= StReq;
        StReq: begin
          // An accepted request under flush is still in flight: drain it.
          if (imem_ready_i) begin
            state_q <= flush_i ? StDrain : StWait;
          end
        end
        StWait: begin
          if (flush_i) begin
            state_q <= imem_rvalid_i ? StReq : StDrain;
          end else if (imem_rvalid_i) begin
            instr_q <= imem_rdata_i;
            state_q <= StValid;
          end
        end
        StDrain: begin
          // A response coinciding with a flush is the one being drained, so
          // nothing stays outstanding; only a bare flush keeps waiting.
          if (imem_rvalid_i) begin
            state_q <= StReq;
          end
        end
        StValid: begin
          if (flush_i || instr_ready_i) begin
            state_q <= StReq;
          end
        end
        StHalt: begin
          state_q <= StHalt;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Outputs depend only on registered state.
  assign imem_req_o    = (state_q == StReq);
  assign imem_addr_o   = imem_req_o ? pc_q : '0;
  assign instr_valid_o = (state_q == StValid);
  assign misaligned_o  = (state_q == StHalt);
  assign instr_o       = instr_valid_o ? instr_q : '0;
  assign opcode_o      = instr_o[OPCODE_W-1:0];
  assign pc_o          = (instr_valid_o || misaligned_o) ? pc_q : '0;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch. A zero-wait memory model
// (ready whenever requested, response the cycle after acceptance) can be
// switched off for hand-driven response sequences.
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [31:0] pc;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush;
  logic [31:0] flush_pc;
  logic        misaligned;

  int unsigned n_checks;
  int unsigned n_fail;
  logic        mem_auto;

  instr_fetch dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_ready_i  (imem_ready),
    .imem_rvalid_i (imem_rvalid),
    .imem_rdata_i  (imem_rdata),
    .instr_valid_o (instr_valid),
    .instr_o       (instr),
    .opcode_o      (opcode),
    .pc_o          (pc),
    .instr_ready_i (instr_ready),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .flush_i       (flush),
    .flush_pc_i    (flush_pc),
    .misaligned_o  (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: address 0 holds addi x1,x0,5; others encode their address.
  function automatic logic [31:0] mem_word(logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return {a[24:0], 7'b0110011};
  endfunction

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One clock; outputs are sampled 1ns after the edge.
  task automatic step();
    logic        acc;
    logic [31:0] acc_addr;
    acc      = imem_req && imem_ready;
    acc_addr = imem_addr;
    @(posedge clk);
    #1;
    if (mem_auto) begin
      imem_ready  = 1'b1;
      imem_rvalid = acc;
      imem_rdata  = acc ? mem_word(acc_addr) : 32'h0;
    end
  endtask

  task automatic consume(logic redir, logic [31:0] target);
    instr_ready = 1'b1;
    redirect    = redir;
    redirect_pc = target;
    step();
    instr_ready = 1'b0;
    redirect    = 1'b0;
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    mem_auto    = 1'b1;
    rst         = 1'b1;
    imem_ready  = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    flush       = 1'b0;
    flush_pc    = 32'h0;

    step();
    step();
    check_eq("rst_req", 32'(imem_req), 32'd0);
    check_eq("rst_addr", imem_addr, 32'h0);
    check_eq("rst_valid", 32'(instr_valid), 32'd0);
    check_eq("rst_instr", instr, 32'h0);
    check_eq("rst_opcode", 32'(opcode), 32'h0);
    check_eq("rst_pc", pc, 32'h0);
    check_eq("rst_misaligned", 32'(misaligned), 32'd0);

    // Zero-wait fetch: REQ in cycle 1, WAIT in cycle 2, VALID in cycle 3.
    rst = 1'b0;
    step();
    check_eq("c1_req", 32'(imem_req), 32'd1);
    check_eq("c1_addr", imem_addr, 32'h0);
    step();
    check_eq("c2_valid", 32'(instr_valid), 32'd0);
    step();
    check_eq("c3_valid", 32'(instr_valid), 32'd1);
    check_eq("c3_instr", instr, 32'h0050_0093);
    check_eq("c3_opcode", 32'(opcode), 32'h13);
    check_eq("c3_pc", pc, 32'h0);
    step();
    check_eq("hold_valid", 32'(instr_valid), 32'd1);
    check_eq("hold_instr", instr, 32'h0050_0093);
    consume(1'b0, 32'h0);
    check_eq("seq_addr", imem_addr, 32'h4);
    check_eq("seq_req", 32'(imem_req), 32'd1);
    step();
    step();
    check_eq("seq_instr", instr, 32'h0000_0233);
    check_eq("seq_pc", pc, 32'h4);

    // Redirect at consume.
    consume(1'b1, 32'h100);
    check_eq("redir_addr", imem_addr, 32'h100);
    step();
    step();
    check_eq("redir_pc", pc, 32'h100);
    check_eq("redir_instr", instr, 32'h0000_8033);

    // Flush while WAIT, stale response arrives during DRAIN.
    consume(1'b0, 32'h0);
    check_eq("pre_flush_addr", imem_addr, 32'h104);
    mem_auto = 1'b0;
    step();
    imem_rvalid = 1'b0;
    flush       = 1'b1;
    flush_pc    = 32'h40;
    step();
    flush       = 1'b0;
    check_eq("drain_req", 32'(imem_req), 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    step();
    imem_rvalid = 1'b0;
    mem_auto    = 1'b1;
    check_eq("flush_req", 32'(imem_req), 32'd1);
    check_eq("flush_addr", imem_addr, 32'h40);
    check_eq("flush_valid", 32'(instr_valid), 32'd0);
    step();
    step();
    check_eq("flush_instr", instr, 32'h0000_2033);
    check_eq("flush_pc", pc, 32'h40);

    // Flush beats redirect at the consume handshake.
    flush    = 1'b1;
    flush_pc = 32'h80;
    consume(1'b1, 32'h200);
    flush    = 1'b0;
    check_eq("prio_addr", imem_addr, 32'h80);
    step();
    step();
    check_eq("prio_pc", pc, 32'h80);

    // PC wraps from 0xFFFF_FFFC to 0.
    consume(1'b1, 32'hFFFF_FFFC);
    check_eq("wrap_pre_addr", imem_addr, 32'hFFFF_FFFC);
    step();
    step();
    check_eq("wrap_pre_pc", pc, 32'hFFFF_FFFC);
    consume(1'b0, 32'h0);
    check_eq("wrap_addr", imem_addr, 32'h0);

    // Reset mid-WAIT; a late response must be ignored.
    step();
    mem_auto    = 1'b0;
    imem_rvalid = 1'b0;
    rst         = 1'b1;
    step();
    check_eq("midwait_rst_req", 32'(imem_req), 32'd0);
    check_eq("midwait_rst_valid", 32'(instr_valid), 32'd0);
    rst         = 1'b0;
    imem_ready  = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    step();
    check_eq("late_req", 32'(imem_req), 32'd1);
    check_eq("late_valid", 32'(instr_valid), 32'd0);
    step();
    check_eq("late_hold_req", 32'(imem_req), 32'd1);
    check_eq("late_hold_valid", 32'(instr_valid), 32'd0);
    imem_rvalid = 1'b0;
    imem_ready  = 1'b1;
    mem_auto    = 1'b1;
    step();
    step();
    check_eq("after_rst_instr", instr, 32'h0050_0093);

    // Misaligned redirect target halts until reset.
    consume(1'b1, 32'h102);
    check_eq("halt_misaligned", 32'(misaligned), 32'd1);
    check_eq("halt_pc", pc, 32'h102);
    check_eq("halt_req", 32'(imem_req), 32'd0);
    flush    = 1'b1;
    flush_pc = 32'h300;
    step();
    step();
    flush    = 1'b0;
    check_eq("halt_sticky", 32'(misaligned), 32'd1);
    check_eq("halt_sticky_req", 32'(imem_req), 32'd0);
    check_eq("halt_sticky_pc", pc, 32'h102);
    rst = 1'b1;
    step();
    check_eq("halt_rst_mis", 32'(misaligned), 32'd0);
    rst = 1'b0;
    step();
    check_eq("halt_rst_req", 32'(imem_req), 32'd1);
    check_eq("halt_rst_addr", imem_addr, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
